// File: rtl/ws_pe_pkg.sv
// Shared state encoding and constants for the weight-stationary PE row controller.
package ws_pe_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_FILL,
    S_RUN,
    S_ROW_END,
    S_DONE
  } state_e;

  localparam int DW    = 10;
  localparam int K_DEF = 3;

endpackage

// File: rtl/ws_pe_cnt.sv
// Up-counter with synchronous clear, count enable, wrap at MAX and terminal flag.
module ws_pe_cnt #(
  parameter int W   = 4,
  parameter int MAX = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == MAX_V) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == MAX_V);

endmodule

// File: rtl/ws_pe_ctrl.sv
// Sequencer for one weight-stationary PE row: weight load, activation streaming, output handshake.
// Optional WS_PE_PERF_EN adds a saturating RUN-stall counter output (stall_cnt).
module ws_pe_ctrl
  import ws_pe_pkg::*;
#(
  parameter int  K        = K_DEF,
  parameter int  IMG_W    = 8,
  parameter int  NUM_ROWS = 6,
  localparam int CW       = $clog2(IMG_W + 1),
  localparam int RW       = $clog2(NUM_ROWS + 1),
  localparam int WAW      = $clog2(K * K)
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  input  logic           w_valid,
  output logic           w_ready,
  output logic           w_we,
  output logic [WAW-1:0] w_addr,
  input  logic           act_valid,
  output logic           act_ready,
  output logic           act_shift,
  output logic           acc_clr,
  output logic           acc_en,
  output logic           out_valid,
  input  logic           out_ready,
`ifdef WS_PE_PERF_EN
  output logic [15:0]    stall_cnt,
`endif
  output logic [CW-1:0]  out_col,
  output logic [RW-1:0]  out_row
);

  // One column counter spans the whole row: 0..K-2 is fill, the rest produce pixels.
  localparam logic [CW-1:0] FILL_LAST = CW'(K - 2);
  localparam logic [CW-1:0] RUN_OFS   = CW'(K - 1);

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          w_ready_q, w_ready_d;
  logic          acc_clr_q, acc_clr_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic [RW-1:0] out_row_q, out_row_d;

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          col_term, row_term, w_term;
  logic          in_idle, w_hs, act_hs, out_hold, row_leave;

  assign in_idle   = (state_q == S_IDLE);
  assign w_hs      = w_valid & w_ready_q;
  assign out_hold  = out_valid_q & ~out_ready;
  assign row_leave = (state_q == S_ROW_END) & ~out_hold;

  always_comb begin
    act_ready = 1'b0;
    if (state_q == S_FILL) begin
      act_ready = 1'b1;
    end else if (state_q == S_RUN) begin
      act_ready = ~out_valid_q | out_ready;
    end
  end

  assign act_hs    = act_valid & act_ready;
  assign act_shift = act_hs;
  assign acc_en    = act_hs & (state_q == S_RUN);
  assign w_we      = w_hs;

  ws_pe_cnt #(.W(WAW), .MAX(K * K - 1)) u_w_cnt (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .clr  (in_idle),
    .en   (w_hs),
    .cnt  (w_addr),
    .term (w_term)
  );

  ws_pe_cnt #(.W(CW), .MAX(IMG_W - 1)) u_col_cnt (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .clr  (in_idle | (state_q == S_ROW_END)),
    .en   (act_hs),
    .cnt  (col_cnt),
    .term (col_term)
  );

  ws_pe_cnt #(.W(RW), .MAX(NUM_ROWS - 1)) u_row_cnt (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .clr  (in_idle),
    .en   (row_leave),
    .cnt  (row_cnt),
    .term (row_term)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_LOAD_W;
      S_LOAD_W:  if (w_hs && w_term) state_d = S_FILL;
      S_FILL:    if (act_hs && (col_cnt == FILL_LAST)) state_d = S_RUN;
      S_RUN:     if (act_hs && col_term) state_d = S_ROW_END;
      S_ROW_END: if (!out_hold) state_d = row_term ? S_DONE : S_FILL;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    w_ready_d = (state_d == S_LOAD_W);
    acc_clr_d = ((state_q == S_IDLE) && (state_d == S_LOAD_W)) ||
                ((state_q != S_ROW_END) && (state_d == S_ROW_END));

    // A pending pixel drops on accept; a new accumulate in the same cycle re-arms it.
    out_valid_d = out_hold;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    if (acc_en) begin
      out_valid_d = 1'b1;
      out_col_d   = col_cnt - RUN_OFS;
      out_row_d   = row_cnt;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      w_ready_q   <= 1'b0;
      acc_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      w_ready_q   <= w_ready_d;
      acc_clr_q   <= acc_clr_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign w_ready   = w_ready_q;
  assign acc_clr   = acc_clr_q;
  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;
  assign out_row   = out_row_q;

`ifdef WS_PE_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_idle && start) begin
      stall_cnt_d = '0;
    end else if ((state_q == S_RUN) && act_valid && !act_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ws_pe_ctrl.sv
// Directed self-checking bench for ws_pe_ctrl (K=3, IMG_W=8, NUM_ROWS=6).
`timescale 1ns/1ps
module tb_ws_pe_ctrl;

  localparam int K           = 3;
  localparam int IMG_W       = 8;
  localparam int NUM_ROWS    = 6;
  localparam int PIX_PER_ROW = IMG_W - K + 1;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n, start, w_valid, act_valid, out_ready;
  logic       busy, done, w_ready, w_we;
  logic [3:0] w_addr;
  logic       act_ready, act_shift, acc_clr, acc_en, out_valid;
  logic [3:0] out_col;
  logic [2:0] out_row;
`ifdef WS_PE_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_we, n_done, n_pix, exp_waddr, exp_col, exp_row;

  always #5 sys_clk = ~sys_clk;

  ws_pe_ctrl #(.K(K), .IMG_W(IMG_W), .NUM_ROWS(NUM_ROWS)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_we     (w_we),
    .w_addr   (w_addr),
    .act_valid(act_valid),
    .act_ready(act_ready),
    .act_shift(act_shift),
    .acc_clr  (acc_clr),
    .acc_en   (acc_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef WS_PE_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .out_col  (out_col),
    .out_row  (out_row)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    n_we = 0; n_done = 0; n_pix = 0;
    exp_waddr = 0; exp_col = 0; exp_row = 0;
  endtask

  // Sample settled outputs and score weight writes, accepted pixels and done pulses.
  task automatic sample();
    #1;
    if (w_we) begin
      chk("w_addr", w_addr, exp_waddr);
      exp_waddr++;
      n_we++;
    end
    if (out_valid && out_ready) begin
      chk("pix_row", out_row, exp_row);
      chk("pix_col", out_col, exp_col);
      n_pix++;
      if (exp_col == PIX_PER_ROW - 1) begin
        exp_col = 0;
        exp_row++;
      end else begin
        exp_col++;
      end
    end
    if (done) begin
      n_done++;
      chk("busy_in_done", busy, 1);
    end
  endtask

  task automatic adv();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  task automatic load_weights(input bit gaps);
    for (int i = 0; i < K * K; i++) begin
      if (gaps) begin
        w_valid = 1'b0;
        sample();
        chk("load_act_ready", act_ready, 0);
        chk("load_act_shift", act_shift, 0);
        adv();
      end
      w_valid = 1'b1;
      cyc();
    end
    w_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    sys_rst_n = 1'b0; start = 1'b0; w_valid = 1'b0; act_valid = 1'b0; out_ready = 1'b0;
    clear_model();
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_acc_clr", acc_clr, 0);
    chk("rst_w_addr", w_addr, 0);
    adv();

    // Full job: weights with gaps, row 0 unstalled, backpressure in row 1.
    out_ready = 1'b1;
    act_valid = 1'b1;
    chk("idle_act_ready", act_ready, 0);
    start = 1'b1;
    sample();
    chk("idle_busy", busy, 0);
    adv();
    start = 1'b0;
    chk("ld_acc_clr", acc_clr, 1);
    chk("ld_busy", busy, 1);
    chk("ld_w_ready", w_ready, 1);
    load_weights(1'b1);
    chk("we_count", n_we, K * K);
    chk("fill_w_ready", w_ready, 0);

    for (int h = 0; h < IMG_W; h++) begin
      sample();
      chk("row0_shift", act_shift, 1);
      chk("row0_acc_en", acc_en, (h >= K - 1));
      adv();
    end
    sample();
    chk("rowend_acc_clr", acc_clr, 1);
    chk("rowend_act_ready", act_ready, 0);
    adv();
    chk("row0_pixels", n_pix, PIX_PER_ROW);

    for (int t = 0; t < 20 && !(out_valid && out_row == 3'd1 && out_col == 4'd2); t++) cyc();
    chk("bp_reached", (out_valid && out_row == 3'd1 && out_col == 4'd2), 1);
    out_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sample();
      chk("bp_act_ready", act_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_col", out_col, 2);
      adv();
    end
    out_ready = 1'b1;
    for (int t = 0; t < 300 && n_done == 0; t++) cyc();
    chk("done_seen", n_done, 1);
    chk("busy_after_done", busy, 0);
    repeat (4) cyc();
    chk("done_single", n_done, 1);
    chk("pix_total", n_pix, NUM_ROWS * PIX_PER_ROW);
    chk("rows_done", exp_row, NUM_ROWS);

    // Asynchronous reset in the middle of RUN.
    clear_model();
    start = 1'b1;
    cyc();
    start = 1'b0;
    load_weights(1'b0);
    repeat (K + 1) cyc();
    chk("mid_run_busy", busy, 1);
    chk("mid_run_valid", out_valid, 1);
    sys_rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_done", done, 0);
    chk("arst_act_ready", act_ready, 0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (3) cyc();
    chk("arst_no_done", n_done, 0);
    chk("arst_idle_busy", busy, 0);

`ifdef WS_PE_PERF_EN
    // Stall counter: one accepted RUN activation, then five blocked cycles.
    clear_model();
    out_ready = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    load_weights(1'b0);
    repeat (K) cyc();
    repeat (5) cyc();
    chk("stall_cnt", stall_cnt, 5);
    out_ready = 1'b1;
    for (int t = 0; t < 300 && n_done == 0; t++) cyc();
    chk("perf_done", n_done, 1);
    chk("stall_keep", stall_cnt, 5);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("stall_clr", stall_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
